// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser serial-to-parallel deserializer.
package sipo_pkg;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

   // Width needed to hold a count in 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Modulo-N bit counter with enable and synchronous clear; last_o flags cnt_o == N-1.
module sipo_bit_counter
   import sipo_pkg::*;
#(
   parameter int N  = 8,
   parameter int CW = cnt_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   input  logic          clr_i,
   output logic [CW-1:0] cnt_o,
   output logic          last_o
);

   localparam logic [CW-1:0] CntLast = CW'(N - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: combinational blocks assign a default first so no path leaves cnt_d unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = last_o ? '0 : cnt_q + CW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == CntLast);

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with a one-entry valid/ready output buffer.
// Optional trailing even-parity check is enabled by defining PARITY_CHECK_EN.
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             bit_vld,
   input  logic             sync_n,
   output logic [WIDTH-1:0] data_out,
   output logic             data_vld,
   input  logic             data_rdy,
   output logic             ovf,
   output logic             parity_err
);

`ifdef PARITY_CHECK_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif
   localparam int CW = cnt_width(N);

   logic             accept, last, complete, shift_en, load, drop;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sr_q, sr_d, sr_shift, word;
   logic [WIDTH-1:0] data_q;
   logic             ovf_q;
   buf_state_e       state_q;

   assign accept   = bit_vld & sync_n;
   assign complete = accept & last;

   sipo_bit_counter #(
      .N  (N),
      .CW (CW)
   ) u_bit_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (accept),
      .clr_i  (~sync_n),
      .cnt_o  (cnt),
      .last_o (last)
   );

   // Completion is fully described by last; the count value itself is not needed here.
   logic unused_cnt;
   assign unused_cnt = ^cnt;

`ifdef PARITY_CHECK_EN
   // The trailing parity bit is checked but never enters the shift register.
   logic perr_q, perr_new;
   assign shift_en = accept & ~last;
   assign word     = sr_q;
   assign perr_new = (^sr_q) ^ bit_in;
`else
   assign shift_en = accept;
   assign word     = sr_shift;
`endif

   always_comb begin
      if (LSB_FIRST) begin
         sr_shift = {bit_in, sr_q[WIDTH-1:1]};
      end else begin
         sr_shift = {sr_q[WIDTH-2:0], bit_in};
      end
      sr_d = sr_q;
      if (!sync_n) begin
         sr_d = '0;
      end else if (shift_en) begin
         sr_d = sr_shift;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   // A completed frame loads unless the buffer is full and not being drained this edge.
   assign load = complete & ((state_q == BUF_EMPTY) | data_rdy);
   assign drop = complete & ~load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BUF_EMPTY;
         data_q  <= '0;
         ovf_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         if (load) begin
            data_q <= word;
`ifdef PARITY_CHECK_EN
            perr_q <= perr_new;
`endif
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end else if (!sync_n) begin
            ovf_q <= 1'b0;
         end
         case (state_q)
            BUF_EMPTY: if (complete) state_q <= BUF_FULL;
            BUF_FULL:  if (data_rdy && !complete) state_q <= BUF_EMPTY;
         endcase
      end
   end

   assign data_out = data_q;
   assign data_vld = (state_q == BUF_FULL);
   assign ovf      = ovf_q;
`ifdef PARITY_CHECK_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: LSB-first and MSB-first instances share one stimulus stream.
module tb_sipo_deser;

   localparam int WIDTH = 8;
`ifdef PARITY_CHECK_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif

   logic clk, rst_n, bit_in, bit_vld, sync_n, data_rdy;
   logic [WIDTH-1:0] d_l, d_m;
   logic v_l, v_m, o_l, o_m, p_l, p_m;

   int n_checks = 0;
   int n_errs   = 0;

   sipo_deser #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) u_dut_lsb (
      .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld), .sync_n(sync_n),
      .data_out(d_l), .data_vld(v_l), .data_rdy(data_rdy), .ovf(o_l), .parity_err(p_l)
   );

   sipo_deser #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) u_dut_msb (
      .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_vld(bit_vld), .sync_n(sync_n),
      .data_out(d_m), .data_vld(v_m), .data_rdy(data_rdy), .ovf(o_m), .parity_err(p_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: collects the frame's bits in a queue and builds words by bit position.
   logic             m_bits[$];
   logic             m_vld  = 1'b0;
   logic [WIDTH-1:0] m_dl   = '0;
   logic [WIDTH-1:0] m_dm   = '0;
   logic             m_ovf  = 1'b0;
   logic             m_perr = 1'b0;

   task automatic model_reset();
      m_bits.delete();
      m_vld  = 1'b0;
      m_dl   = '0;
      m_dm   = '0;
      m_ovf  = 1'b0;
      m_perr = 1'b0;
   endtask

   task automatic model_step(input logic bi, input logic bv, input logic sn, input logic rdy);
      logic done;
      logic [WIDTH-1:0] wl, wm;
      logic pe;
      done = 1'b0;
      wl = '0;
      wm = '0;
      pe = 1'b0;
      if (!sn) begin
         m_bits.delete();
         m_ovf = 1'b0;
      end else if (bv) begin
         m_bits.push_back(bi);
         if (m_bits.size() == N) begin
            done = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
               wl[i] = m_bits[i];
               wm[WIDTH-1-i] = m_bits[i];
            end
            for (int i = 0; i < N; i++) pe = pe ^ m_bits[i];
            m_bits.delete();
         end
      end
      if (done) begin
         if (!m_vld || rdy) begin
            m_vld = 1'b1;
            m_dl  = wl;
            m_dm  = wm;
`ifdef PARITY_CHECK_EN
            m_perr = pe;
`endif
         end else begin
            m_ovf = 1'b1;
         end
      end else if (m_vld && rdy) begin
         m_vld = 1'b0;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model(input string tag);
      check({tag, "_vld_l"},  32'(v_l), 32'(m_vld));
      check({tag, "_vld_m"},  32'(v_m), 32'(m_vld));
      check({tag, "_data_l"}, 32'(d_l), 32'(m_dl));
      check({tag, "_data_m"}, 32'(d_m), 32'(m_dm));
      check({tag, "_ovf_l"},  32'(o_l), 32'(m_ovf));
      check({tag, "_ovf_m"},  32'(o_m), 32'(m_ovf));
      check({tag, "_perr_l"}, 32'(p_l), 32'(m_perr));
      check({tag, "_perr_m"}, 32'(p_m), 32'(m_perr));
   endtask

   // Drive one cycle of inputs, advance the model, and compare one time unit after the edge.
   task automatic step(input logic bi, input logic bv, input logic sn, input logic rdy);
      bit_in   = bi;
      bit_vld  = bv;
      sync_n   = sn;
      data_rdy = rdy;
      model_step(bi, bv, sn, rdy);
      @(posedge clk);
      #1;
      compare_model("mdl");
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] w, input logic par,
                             input logic rdy_body, input logic rdy_last);
      for (int i = 0; i < N; i++) begin
         logic b;
         b = (i < WIDTH) ? w[i] : par;
         step(b, 1'b1, 1'b1, (i == N - 1) ? rdy_last : rdy_body);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data_l"}, 32'(d_l), 32'h0);
      check({tag, "_data_m"}, 32'(d_m), 32'h0);
      check({tag, "_vld_l"},  32'(v_l), 32'h0);
      check({tag, "_vld_m"},  32'(v_m), 32'h0);
      check({tag, "_ovf_l"},  32'(o_l), 32'h0);
      check({tag, "_perr_l"}, 32'(p_l), 32'h0);
   endtask

   typedef struct {
      logic             bi, bv, sn, rdy;
      logic             ev;
      logic [WIDTH-1:0] el, em;
      logic             eo;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [WIDTH-1:0] stim;

      // Reset state.
      bit_in   = 1'b0;
      bit_vld  = 1'b0;
      sync_n   = 1'b1;
      data_rdy = 1'b0;
      rst_n    = 1'b0;
      #3;
      check_all_zero("reset");
      #4;
      rst_n = 1'b1;

      // Table: bits 1,0,1,0,0,1,1,0 with data_rdy=1 -> 8'h65 (LSB first) / 8'hA6 (MSB first).
      stim = 8'h65;
      for (int i = 0; i < WIDTH; i++) begin
         vecs.push_back('{bi: stim[i], bv: 1'b1, sn: 1'b1, rdy: 1'b1,
                          ev: (i == N - 1),
                          el: (i == N - 1) ? 8'h65 : 8'h00,
                          em: (i == N - 1) ? 8'hA6 : 8'h00,
                          eo: 1'b0});
      end
`ifdef PARITY_CHECK_EN
      vecs.push_back('{bi: 1'b0, bv: 1'b1, sn: 1'b1, rdy: 1'b1, ev: 1'b1,
                       el: 8'h65, em: 8'hA6, eo: 1'b0});
`endif
      vecs.push_back('{bi: 1'b0, bv: 1'b0, sn: 1'b1, rdy: 1'b1, ev: 1'b0,
                       el: 8'h65, em: 8'hA6, eo: 1'b0});
      vecs.push_back('{bi: 1'b1, bv: 1'b0, sn: 1'b1, rdy: 1'b1, ev: 1'b0,
                       el: 8'h65, em: 8'hA6, eo: 1'b0});
      foreach (vecs[k]) begin
         step(vecs[k].bi, vecs[k].bv, vecs[k].sn, vecs[k].rdy);
         check("tbl_vld",    32'(v_l), 32'(vecs[k].ev));
         check("tbl_data_l", 32'(d_l), 32'(vecs[k].el));
         check("tbl_data_m", 32'(d_m), 32'(vecs[k].em));
         check("tbl_ovf",    32'(o_l), 32'(vecs[k].eo));
      end

      // Overflow: consumer stalled across two completions.
      send_frame(8'h11, 1'b0, 1'b0, 1'b0);
      check("ovf_first_l", 32'(d_l), 32'h11);
      check("ovf_first_m", 32'(d_m), 32'h88);
      check("ovf_first_vld", 32'(v_l), 32'h1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0);
      check("ovf_hold_data", 32'(d_l), 32'h11);
      check("ovf_set_l", 32'(o_l), 32'h1);
      check("ovf_set_m", 32'(o_m), 32'h1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("sync_clr_ovf", 32'(o_l), 32'h0);
      check("sync_keep_vld", 32'(v_l), 32'h1);
      check("sync_keep_data", 32'(d_l), 32'h11);

      // Pass-through: completion in the same cycle the consumer drains.
      send_frame(8'h33, 1'b0, 1'b0, 1'b1);
      check("pass_data_l", 32'(d_l), 32'h33);
      check("pass_data_m", 32'(d_m), 32'hCC);
      check("pass_vld", 32'(v_l), 32'h1);
      check("pass_no_ovf", 32'(o_l), 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("drain_vld", 32'(v_l), 32'h0);

      // Partial frame discarded by sync_n with bit_vld high.
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
      check("resync_data_l", 32'(d_l), 32'h5A);
      check("resync_data_m", 32'(d_m), 32'h5A);
      check("resync_vld", 32'(v_l), 32'h1);

      // Asynchronous reset mid-frame while the buffer is full.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      #1;
      rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b1);

`ifdef PARITY_CHECK_EN
      send_frame(8'h03, 1'b0, 1'b1, 1'b1);
      check("par_ok_data", 32'(d_l), 32'h03);
      check("par_ok_err", 32'(p_l), 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      send_frame(8'h07, 1'b0, 1'b1, 1'b1);
      check("par_bad_data", 32'(d_l), 32'h07);
      check("par_bad_err", 32'(p_l), 32'h1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
`endif

      // Randomized traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         step(1'($urandom_range(1)),
              1'($urandom_range(3) != 0),
              1'($urandom_range(31) != 0),
              1'($urandom_range(1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
